ext_obi_copy_master: RTL and testbench

Register-programmed block-copy engine that drives one of the external OBI master ports into the X-HEEP system bus; until now those ports are tied off. Software configures it through a register-interface slave hung off the external peripheral port. The engine then moves a block of 32-bit words from a source address to a destination address, one outstanding OBI transaction at a time. Completion is signalled by a status bit and a one-cycle interrupt pulse routed into the external interrupt vector.

---
 rtl/ext_obi_copy_master.sv | 218 +++++++++++++++++++++
 tb/tb_ext_obi_copy_master.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_obi_copy_master.sv
`timescale 1ns/1ps
// ext_obi_copy_master: register-programmed block-copy engine driving one OBI master port.
// Moves LEN 32-bit words from SRC to DST with a single outstanding transaction.

package ext_obi_copy_master_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

module ext_obi_copy_master
  import ext_obi_copy_master_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_ni,
  input  reg_req_t  reg_req_i,
  output reg_rsp_t  reg_rsp_o,
  output obi_req_t  master_req_o,
  input  obi_resp_t master_resp_i,
  output logic      intr_o
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned LW = 16;
  localparam int unsigned OW = 5;

  localparam logic [OW-1:0] OFF_SRC    = 5'h00;
  localparam logic [OW-1:0] OFF_DST    = 5'h04;
  localparam logic [OW-1:0] OFF_LEN    = 5'h08;
  localparam logic [OW-1:0] OFF_CTRL   = 5'h0C;
  localparam logic [OW-1:0] OFF_STATUS = 5'h10;
  localparam logic [3:0]    BE_ALL     = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_WR_REQ,
    S_WR_WAIT
  } state_e;

  state_e        state_q;
  logic [AW-1:0] src_q, dst_q;
  logic [LW-1:0] len_q;
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [LW-1:0] cnt_q;
  logic          done_q;
  logic          intr_q;
  obi_req_t      req_q;

  logic          busy_c;
  logic [OW-1:0] off_c;
  logic [DW-1:0] rdata_c;
  logic          err_c;
  logic          wr_src_c, wr_dst_c, wr_len_c, start_c;
  logic          unused_bits;

  assign busy_c      = (state_q != S_IDLE);
  assign off_c       = reg_req_i.addr[OW-1:0];
  assign unused_bits = ^{reg_req_i.addr[AW-1:OW], reg_req_i.wstrb};

  // Config slave decode: combinational response, writes blocked while busy.
  always_comb begin
    rdata_c  = '0;
    err_c    = 1'b0;
    wr_src_c = 1'b0;
    wr_dst_c = 1'b0;
    wr_len_c = 1'b0;
    start_c  = 1'b0;
    if (reg_req_i.valid) begin
      unique case (off_c)
        OFF_SRC: begin
          rdata_c = src_q;
          if (reg_req_i.write) begin
            err_c    = busy_c;
            wr_src_c = !busy_c;
          end
        end
        OFF_DST: begin
          rdata_c = dst_q;
          if (reg_req_i.write) begin
            err_c    = busy_c;
            wr_dst_c = !busy_c;
          end
        end
        OFF_LEN: begin
          rdata_c = DW'(len_q);
          if (reg_req_i.write) begin
            err_c    = busy_c;
            wr_len_c = !busy_c;
          end
        end
        OFF_CTRL: begin
          if (reg_req_i.write) begin
            err_c   = busy_c;
            start_c = !busy_c && reg_req_i.wdata[0];
          end
        end
        OFF_STATUS: begin
          rdata_c = {{(DW-2){1'b0}}, done_q, busy_c};
          err_c   = reg_req_i.write;
        end
        default: err_c = 1'b1;
      endcase
    end
  end

  assign reg_rsp_o    = '{rdata: rdata_c, error: err_c, ready: 1'b1};
  assign master_req_o = req_q;
  assign intr_o       = intr_q;

  // Config registers, copy FSM and registered OBI request.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      intr_q   <= 1'b0;
      req_q    <= '0;
    end else begin
      intr_q <= 1'b0;
      if (wr_src_c) src_q <= {reg_req_i.wdata[AW-1:2], 2'b00};
      if (wr_dst_c) dst_q <= {reg_req_i.wdata[AW-1:2], 2'b00};
      if (wr_len_c) len_q <= reg_req_i.wdata[LW-1:0];

      unique case (state_q)
        S_IDLE: begin
          if (start_c) begin
            if (len_q != '0) begin
              rd_ptr_q <= src_q;
              wr_ptr_q <= dst_q;
              cnt_q    <= len_q;
              done_q   <= 1'b0;
              req_q    <= '{req: 1'b1, we: 1'b0, be: BE_ALL, addr: src_q, wdata: '0};
              state_q  <= S_RD_REQ;
            end else begin
              done_q <= 1'b1;
              intr_q <= 1'b1;
            end
          end
        end
        S_RD_REQ: begin
          if (master_resp_i.gnt) begin
            req_q   <= '0;
            state_q <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          // The request's wdata field doubles as the word buffer.
          if (master_resp_i.rvalid) begin
            req_q   <= '{req: 1'b1, we: 1'b1, be: BE_ALL, addr: wr_ptr_q,
                         wdata: master_resp_i.rdata};
            state_q <= S_WR_REQ;
          end
        end
        S_WR_REQ: begin
          if (master_resp_i.gnt) begin
            req_q   <= '0;
            state_q <= S_WR_WAIT;
          end
        end
        S_WR_WAIT: begin
          if (master_resp_i.rvalid) begin
            rd_ptr_q <= rd_ptr_q + AW'(4);
            wr_ptr_q <= wr_ptr_q + AW'(4);
            cnt_q    <= cnt_q - LW'(1);
            if (cnt_q == LW'(1)) begin
              done_q  <= 1'b1;
              intr_q  <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              req_q   <= '{req: 1'b1, we: 1'b0, be: BE_ALL, addr: rd_ptr_q + AW'(4),
                           wdata: '0};
              state_q <= S_RD_REQ;
            end
          end
        end
        default: begin
          req_q   <= '0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ext_obi_copy_master.sv
`timescale 1ns/1ps
// Self-checking bench for ext_obi_copy_master: OBI memory model with optional random
// stalls, and a word-level copy reference (expected destination = source words).

module tb_ext_obi_copy_master;
  import ext_obi_copy_master_pkg::*;

  localparam logic [31:0] A_SRC    = 32'h00;
  localparam logic [31:0] A_DST    = 32'h04;
  localparam logic [31:0] A_LEN    = 32'h08;
  localparam logic [31:0] A_CTRL   = 32'h0C;
  localparam logic [31:0] A_STATUS = 32'h10;

  logic      clk = 1'b0;
  logic      rst_n = 1'b0;
  reg_req_t  rreq;
  reg_rsp_t  rrsp;
  obi_req_t  mreq;
  obi_resp_t mresp;
  logic      intr;

  always #5 clk = ~clk;

  ext_obi_copy_master dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .reg_req_i    (rreq),
    .reg_rsp_o    (rrsp),
    .master_req_o (mreq),
    .master_resp_i(mresp),
    .intr_o       (intr)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Source memory written by the stimulus; destination memory written only by the slave.
  logic [31:0] rd_mem [logic [31:0]];
  logic [31:0] wr_mem [logic [31:0]];
  logic [31:0] exp_words [64];

  bit stall_mode = 1'b0;
  int rsp_fixed  = 0;
  int clr_gen    = 0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int       clr_seen = 0;
  int       txn_cnt = 0, intr_cnt = 0, intr_cyc = -1, first_req_cyc = -1;
  int       stab_err = 0, stab_cmp = 0;
  bit       req_active = 1'b0, rsp_pend = 1'b0;
  int       gnt_wait = 0, rsp_cnt = 0;
  logic [31:0] rsp_data = '0;
  obi_req_t held;

  function automatic logic [31:0] src_rd(input logic [31:0] a);
    return rd_mem.exists(a) ? rd_mem[a] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] dst_rd(input logic [31:0] a);
    return wr_mem.exists(a) ? wr_mem[a] : 32'hBAD0_0000;
  endfunction

  // OBI slave memory and transfer monitor.
  initial begin
    mresp = '0;
    held  = '0;
    forever begin
      @(negedge clk);
      mresp = '0;
      if (clr_seen != clr_gen) begin
        clr_seen = clr_gen;
        txn_cnt = 0; intr_cnt = 0; intr_cyc = -1; first_req_cyc = -1;
      end
      if (intr) begin
        intr_cnt++;
        if (intr_cyc < 0) intr_cyc = cyc;
      end
      if (mreq.req && first_req_cyc < 0) first_req_cyc = cyc;
      if (rsp_pend) begin
        if (rsp_cnt == 0) begin
          mresp.rvalid = 1'b1;
          mresp.rdata  = rsp_data;
          rsp_pend     = 1'b0;
        end else rsp_cnt--;
      end
      if (!mreq.req) req_active = 1'b0;
      else begin
        if (!req_active) begin
          req_active = 1'b1;
          held       = mreq;
          gnt_wait   = stall_mode ? int'($urandom_range(0, 5)) : 0;
        end else begin
          stab_cmp++;
          if (mreq !== held) stab_err++;
        end
        if (gnt_wait == 0) begin
          mresp.gnt  = 1'b1;
          req_active = 1'b0;
          txn_cnt++;
          if (mreq.we) begin
            wr_mem[mreq.addr] = mreq.wdata;
            rsp_data = '0;
          end else rsp_data = src_rd(mreq.addr);
          rsp_pend = 1'b1;
          rsp_cnt  = stall_mode ? int'($urandom_range(0, 5)) : rsp_fixed;
        end else gnt_wait--;
      end
    end
  end

  task automatic reg_access(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                            output logic [31:0] rd, output logic err);
    @(negedge clk);
    rreq.addr  = addr;
    rreq.write = wr;
    rreq.wdata = wd;
    rreq.wstrb = 4'hF;
    rreq.valid = 1'b1;
    #1;
    rd  = rrsp.rdata;
    err = rrsp.error;
    @(posedge clk);
    #1;
    rreq.valid = 1'b0;
    rreq.write = 1'b0;
  endtask

  task automatic reg_wr(input string tag, input logic [31:0] addr, input logic [31:0] wd,
                        input logic exp_err);
    logic [31:0] rd;
    logic err;
    reg_access(addr, 1'b1, wd, rd, err);
    chk(tag, 96'(err), 96'(exp_err));
  endtask

  task automatic reg_rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] rd;
    logic err;
    reg_access(addr, 1'b0, '0, rd, err);
    chk(tag, 96'(rd), 96'(exp));
    chk({tag, "_err"}, 96'(err), 96'(0));
  endtask

  task automatic fill(input logic [31:0] src, input logic [31:0] dst, input int n,
                      input bit pattern);
    for (int i = 0; i < n; i++) begin
      exp_words[i] = pattern ? 32'hA0 + 32'(i) : $urandom;
      rd_mem[src + 32'(4 * i)] = exp_words[i];
    end
  endtask

  task automatic start_copy(input logic [31:0] src, input logic [31:0] dst, input int n);
    reg_wr("wr_src", A_SRC, src, 1'b0);
    reg_wr("wr_dst", A_DST, dst, 1'b0);
    reg_wr("wr_len", A_LEN, 32'(n), 1'b0);
    clr_gen++;
    reg_wr("wr_ctrl", A_CTRL, 32'h1, 1'b0);
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (intr_cnt > 0) break;
    end
    chk({tag, "_done_seen"}, 96'(intr_cnt > 0), 96'(1));
    repeat (5) @(negedge clk);
  endtask

  task automatic check_copy(input string tag, input logic [31:0] dst, input int n);
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_word%0d", tag, i), 96'(dst_rd(dst + 32'(4 * i))), 96'(exp_words[i]));
    chk({tag, "_no_overrun"}, 96'(wr_mem.exists(dst + 32'(4 * n))), 96'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic err;
    int txn_at_rst;
    bit found;
    rreq = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_master_req", 96'(mreq), 96'(0));
    chk("rst_intr", 96'(intr), 96'(0));
    chk("rst_rsp_rdata", 96'(rrsp.rdata), 96'(0));
    chk("rst_rsp_error", 96'(rrsp.error), 96'(0));
    rst_n = 1'b1;
    reg_rd("rst_status", A_STATUS, 32'h0);
    reg_rd("rst_src", A_SRC, 32'h0);
    reg_rd("rst_len", A_LEN, 32'h0);

    // Readback and decode errors
    reg_wr("rb_wr_src", A_SRC, 32'h1003, 1'b0);
    reg_wr("rb_wr_dst", A_DST, 32'h2000, 1'b0);
    reg_wr("rb_wr_len", A_LEN, 32'h12345, 1'b0);
    reg_rd("rb_src", A_SRC, 32'h1000);
    reg_rd("rb_dst", A_DST, 32'h2000);
    reg_rd("rb_len", A_LEN, 32'h2345);
    reg_rd("rb_ctrl", A_CTRL, 32'h0);
    reg_rd("rb_dst_alias", 32'hFFFF_FFE4, 32'h2000);
    reg_access(32'h14, 1'b0, '0, rd, err);
    chk("bad_offset_err", 96'(err), 96'(1));
    reg_wr("status_wr_err", A_STATUS, 32'h3, 1'b1);

    // Four-word copy, zero-wait memory
    fill(32'h1000, 32'h3000, 4, 1'b1);
    start_copy(32'h1000, 32'h3000, 4);
    wait_done("copy4", 500);
    chk("copy4_cycles", 96'(intr_cyc - first_req_cyc), 96'(16));
    chk("copy4_intr_cnt", 96'(intr_cnt), 96'(1));
    chk("copy4_txn", 96'(txn_cnt), 96'(8));
    reg_rd("copy4_status", A_STATUS, 32'h2);
    check_copy("copy4", 32'h3000, 4);

    // LEN=0 start
    reg_wr("len0_wr_len", A_LEN, 32'h0, 1'b0);
    clr_gen++;
    reg_wr("len0_ctrl", A_CTRL, 32'h1, 1'b0);
    repeat (6) @(negedge clk);
    chk("len0_txn", 96'(txn_cnt), 96'(0));
    chk("len0_intr_cnt", 96'(intr_cnt), 96'(1));
    reg_rd("len0_status", A_STATUS, 32'h2);

    // Random gnt/rvalid stalls
    stall_mode = 1'b1;
    fill(32'h1_0000, 32'h2_0000, 8, 1'b0);
    start_copy(32'h1_0000, 32'h2_0000, 8);
    wait_done("stall", 3000);
    stall_mode = 1'b0;
    chk("stall_txn", 96'(txn_cnt), 96'(16));
    chk("stall_intr_cnt", 96'(intr_cnt), 96'(1));
    chk("stall_req_stable", 96'(stab_err), 96'(0));
    chk("stall_waits_seen", 96'(stab_cmp > 0), 96'(1));
    check_copy("stall", 32'h2_0000, 8);
    reg_rd("stall_status", A_STATUS, 32'h2);

    // Busy protection
    fill(32'h4000, 32'h6000, 8, 1'b0);
    start_copy(32'h4000, 32'h6000, 8);
    reg_wr("busy_dst_err", A_DST, 32'h5000, 1'b1);
    reg_wr("busy_ctrl_err", A_CTRL, 32'h1, 1'b1);
    reg_rd("busy_status", A_STATUS, 32'h1);
    wait_done("busy", 1000);
    chk("busy_intr_cnt", 96'(intr_cnt), 96'(1));
    chk("busy_txn", 96'(txn_cnt), 96'(16));
    check_copy("busy", 32'h6000, 8);
    chk("busy_no_write_5000", 96'(wr_mem.exists(32'h5000)), 96'(0));
    reg_rd("busy_dst_kept", A_DST, 32'h6000);

    // Reset during the second word's write request
    rsp_fixed = 4;
    fill(32'h7000, 32'h8000, 4, 1'b0);
    start_copy(32'h7000, 32'h8000, 4);
    found = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (mreq.req && mreq.we && mreq.addr == 32'h8004) begin
        found = 1'b1;
        break;
      end
    end
    chk("rst_mid_found_wr2", 96'(found), 96'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_req_drop", 96'(mreq.req), 96'(0));
    txn_at_rst = txn_cnt;
    reg_rd("rst_mid_status", A_STATUS, 32'h0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    rsp_fixed = 0;
    chk("rst_mid_no_new_txn", 96'(txn_cnt), 96'(txn_at_rst));
    chk("rst_mid_no_intr", 96'(intr_cnt), 96'(0));
    reg_rd("rst_mid_status_after", A_STATUS, 32'h0);
    reg_rd("rst_mid_src_cleared", A_SRC, 32'h0);
    fill(32'h7000, 32'h9000, 4, 1'b0);
    start_copy(32'h7000, 32'h9000, 4);
    wait_done("after_rst", 500);
    chk("after_rst_intr_cnt", 96'(intr_cnt), 96'(1));
    check_copy("after_rst", 32'h9000, 4);
    reg_rd("after_rst_status", A_STATUS, 32'h2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
